// File: rtl/tdm_demux4.sv
// Receive side of an N_CH-slot TDM link: tracks slot position from the frame
// marker, collects slot words and publishes complete frames in parallel.
module tdm_demux4 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_CH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        din,
  input  logic                    din_valid,
  input  logic                    frame_start,
  output logic [N_CH*WIDTH-1:0]   dout,
  output logic                    dout_valid,
  output logic                    frame_err,
  output logic                    locked
);

  localparam int unsigned SLOT_W = $clog2(N_CH);
  localparam int unsigned SHW_W  = (N_CH - 1) * WIDTH;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_CH - 1);

  typedef enum logic {HUNT = 1'b0, RECV = 1'b1} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [SLOT_W-1:0]       r_slot;
  logic [SLOT_W-1:0]       w_slot_nxt;
  logic [SHW_W-1:0]        r_shadow;
  logic [SHW_W-1:0]        w_shadow_nxt;
  logic [N_CH*WIDTH-1:0]   r_dout;
  logic [N_CH*WIDTH-1:0]   w_dout_nxt;
  logic                    r_dout_valid;
  logic                    w_dout_valid_nxt;
  logic                    r_frame_err;
  logic                    w_frame_err_nxt;
  logic                    r_locked;
  logic                    w_wr_en;
  logic [SLOT_W-1:0]       w_wr_idx;

  // State, slot tracking and frame assembly decisions
  always_comb begin
    w_state_nxt      = r_state;
    w_slot_nxt       = r_slot;
    w_dout_nxt       = r_dout;
    w_dout_valid_nxt = 1'b0;
    w_frame_err_nxt  = 1'b0;
    w_wr_en          = 1'b0;
    w_wr_idx         = '0;

    if (din_valid) begin
      case (r_state)
        HUNT: begin
          if (frame_start) begin
            w_wr_en     = 1'b1;
            w_slot_nxt  = SLOT_W'(1);
            w_state_nxt = RECV;
          end
        end
        RECV: begin
          if (frame_start) begin
            // Early marker drops the partial frame and restarts at slot 0
            w_frame_err_nxt = (r_slot != '0);
            w_wr_en         = 1'b1;
            w_slot_nxt      = SLOT_W'(1);
          end else if (r_slot == '0) begin
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = HUNT;
          end else if (r_slot == LAST_SLOT) begin
            w_dout_nxt       = {din, r_shadow};
            w_dout_valid_nxt = 1'b1;
            w_slot_nxt       = '0;
          end else begin
            w_wr_en    = 1'b1;
            w_wr_idx   = r_slot;
            w_slot_nxt = r_slot + SLOT_W'(1);
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
  end

  // Shadow write port: one slot word per accepted cycle
  always_comb begin
    w_shadow_nxt = r_shadow;
    for (int unsigned k = 0; k < N_CH - 1; k++) begin
      if (w_wr_en && (w_wr_idx == SLOT_W'(k))) begin
        w_shadow_nxt[k*WIDTH +: WIDTH] = din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= HUNT;
      r_slot       <= '0;
      r_shadow     <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_slot       <= w_slot_nxt;
      r_shadow     <= w_shadow_nxt;
      r_dout       <= w_dout_nxt;
      r_dout_valid <= w_dout_valid_nxt;
      r_frame_err  <= w_frame_err_nxt;
      r_locked     <= (w_state_nxt == RECV);
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign frame_err  = r_frame_err;
  assign locked     = r_locked;

endmodule
